// File: rtl/note_scroller_pkg.sv
// Shared definitions for the note scroller: packet layout, lane geometry,
// screen height and the per-slot record.
package note_scroller_pkg;

  localparam int PKT_SLOT_LSB = 26;
  localparam int PKT_ID_LSB   = 20;
  localparam int PKT_Y_LSB    = 10;
  localparam int PKT_X_LSB    = 0;

  localparam logic [10:0] SCREEN_H = 11'd480;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_HIT,
    ST_CLEAR,
    ST_EMIT
  } state_t;

  typedef struct packed {
    logic [1:0] lane;
    logic [5:0] id;
    logic [9:0] y;
  } slot_t;

  // Lanes are 120 px apart, starting 44 px in from the left edge.
  function automatic logic [9:0] lane_x(input logic [1:0] lane);
    case (lane)
      2'd0:    return 10'd44;
      2'd1:    return 10'd164;
      2'd2:    return 10'd284;
      default: return 10'd404;
    endcase
  endfunction

  function automatic logic [31:0] make_pkt(input logic [5:0] slot, input logic [5:0] id,
                                           input logic [9:0] y, input logic [9:0] x);
    logic [31:0] p;
    p = '0;
    p[PKT_SLOT_LSB +: 6] = slot;
    p[PKT_ID_LSB   +: 6] = id;
    p[PKT_Y_LSB    +: 10] = y;
    p[PKT_X_LSB    +: 10] = x;
    return p;
  endfunction

endpackage

// File: rtl/note_scroller_slot_prio_enc.sv
// Lowest-set-bit priority encoder; used to find the first free note slot.
module slot_prio_enc #(
  parameter int WIDTH = 64,
  parameter int IDXW  = 6
) (
  input  logic [WIDTH-1:0] i_mask,
  output logic [IDXW-1:0]  o_idx,
  output logic             o_any
);

  // Walk downward so the lowest set index is the last one written.
  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (i_mask[i]) begin
        o_idx = IDXW'(i);
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/note_scroller.sv
// Note-slot engine: spawns notes into free slots, scrolls them once per frame,
// resolves player hits and streams slot updates to the display stage.
module note_scroller
  import note_scroller_pkg::*;
#(
  parameter int         LANES    = 4,
  parameter int         SLOTS    = 64,
  parameter logic [9:0] HIT_Y_LO = 10'd400
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_frame_tick,
  input  logic [2:0]                 i_speed,
  input  logic                       i_spawn_valid,
  output logic                       o_spawn_ready,
  input  logic [$clog2(LANES)-1:0]   i_spawn_lane,
  input  logic [5:0]                 i_spawn_id,
  input  logic                       i_hit_valid,
  output logic                       o_hit_ready,
  input  logic [$clog2(LANES)-1:0]   i_hit_lane,
  input  logic                       i_clear_all,
  output logic                       o_pkt_valid,
  input  logic                       i_pkt_ready,
  output logic [31:0]                o_pkt_data,
  output logic                       o_hit_pulse,
  output logic                       o_whiff_pulse,
  output logic                       o_miss_pulse,
  output logic [6:0]                 o_active_count
);

  localparam int LANE_W = $clog2(LANES);
  localparam int SLOT_W = $clog2(SLOTS);

  state_t             r_state, r_ret_state;
  logic [SLOT_W:0]    r_idx;
  logic [SLOTS-1:0]   r_valid;
  logic               r_frame_pend, r_clear_pend;
  logic [2:0]         r_speed;
  logic [LANE_W-1:0]  r_hit_lane;
  logic               r_best_found;
  logic [9:0]         r_best_y;
  logic [SLOT_W-1:0]  r_best_idx;
  logic               r_pkt_valid;
  logic [31:0]        r_pkt_data;
  logic               r_hit_pulse, r_whiff_pulse, r_miss_pulse;
  logic [6:0]         r_active_count;
  slot_t              r_slots [SLOTS];

  logic [SLOT_W-1:0]  w_cur_idx, w_free_idx;
  slot_t              w_cur;
  logic [10:0]        w_y_new;
  logic               w_idx_done, w_free_any, w_on_screen, w_hit_cand;
  logic               w_idle_free, w_spawn_fire, w_scan_live, w_go_clear;

  slot_prio_enc #(.WIDTH(SLOTS), .IDXW(SLOT_W)) u_free_enc (
    .i_mask (~r_valid),
    .o_idx  (w_free_idx),
    .o_any  (w_free_any)
  );

  assign w_cur_idx   = r_idx[SLOT_W-1:0];
  assign w_idx_done  = r_idx[SLOT_W];
  assign w_cur       = r_slots[w_cur_idx];
  assign w_y_new     = {1'b0, w_cur.y} + {8'd0, r_speed};
  assign w_on_screen = w_y_new < SCREEN_H;
  assign w_hit_cand  = r_valid[w_cur_idx] && (w_cur.lane == r_hit_lane) &&
                       (w_cur.y >= HIT_Y_LO) && ({1'b0, w_cur.y} < SCREEN_H);

  // Handshake readies follow the IDLE priority order: clear, frame, hit, spawn.
  assign w_idle_free   = (r_state == ST_IDLE) && !r_clear_pend && !r_frame_pend;
  assign o_hit_ready   = !i_reset && w_idle_free && i_hit_valid;
  assign o_spawn_ready = !i_reset && w_idle_free && !i_hit_valid && w_free_any;
  assign w_spawn_fire  = i_spawn_valid && o_spawn_ready;
  assign w_scan_live   = (r_state == ST_SCAN) && !r_clear_pend && !w_idx_done &&
                         r_valid[w_cur_idx];
  // A pending clear preempts scans and hits, but never cuts a packet short.
  assign w_go_clear    = r_clear_pend &&
                         ((r_state == ST_IDLE) || (r_state == ST_SCAN) || (r_state == ST_HIT) ||
                          ((r_state == ST_EMIT) && i_pkt_ready));

  always_ff @(posedge i_clk) begin
    if (w_spawn_fire) begin
      r_slots[w_free_idx] <= '{lane: i_spawn_lane, id: i_spawn_id, y: 10'd0};
    end else if (w_scan_live && w_on_screen) begin
      r_slots[w_cur_idx].y <= w_y_new[9:0];
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= ST_IDLE;
      r_ret_state    <= ST_IDLE;
      r_idx          <= '0;
      r_valid        <= '0;
      r_frame_pend   <= 1'b0;
      r_clear_pend   <= 1'b0;
      r_speed        <= '0;
      r_hit_lane     <= '0;
      r_best_found   <= 1'b0;
      r_best_y       <= '0;
      r_best_idx     <= '0;
      r_pkt_valid    <= 1'b0;
      r_pkt_data     <= '0;
      r_hit_pulse    <= 1'b0;
      r_whiff_pulse  <= 1'b0;
      r_miss_pulse   <= 1'b0;
      r_active_count <= '0;
    end else begin
      r_hit_pulse   <= 1'b0;
      r_whiff_pulse <= 1'b0;
      r_miss_pulse  <= 1'b0;
      if (w_go_clear) begin
        r_state        <= ST_CLEAR;
        r_idx          <= '0;
        r_valid        <= '0;
        r_active_count <= '0;
        r_clear_pend   <= 1'b0;
        r_pkt_valid    <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (r_frame_pend) begin
              r_state      <= ST_SCAN;
              r_speed      <= i_speed;
              r_frame_pend <= 1'b0;
              r_idx        <= '0;
            end else if (o_hit_ready) begin
              r_state      <= ST_HIT;
              r_hit_lane   <= i_hit_lane;
              r_idx        <= '0;
              r_best_found <= 1'b0;
            end else if (w_spawn_fire) begin
              r_valid[w_free_idx] <= 1'b1;
              r_active_count      <= r_active_count + 1'b1;
            end
          end
          ST_SCAN: begin
            if (w_idx_done) begin
              r_state <= ST_IDLE;
            end else begin
              r_idx <= r_idx + 1'b1;
              if (r_valid[w_cur_idx]) begin
                r_pkt_valid <= 1'b1;
                r_state     <= ST_EMIT;
                r_ret_state <= ST_SCAN;
                if (w_on_screen) begin
                  r_pkt_data <= make_pkt(w_cur_idx, w_cur.id, w_y_new[9:0], lane_x(w_cur.lane));
                end else begin
                  r_pkt_data          <= make_pkt(w_cur_idx, 6'd0, 10'd0, 10'd0);
                  r_valid[w_cur_idx]  <= 1'b0;
                  r_active_count      <= r_active_count - 1'b1;
                  r_miss_pulse        <= 1'b1;
                end
              end
            end
          end
          ST_HIT: begin
            if (!w_idx_done) begin
              r_idx <= r_idx + 1'b1;
              // Strict compare keeps the lowest index on equal y.
              if (w_hit_cand && (!r_best_found || (w_cur.y > r_best_y))) begin
                r_best_found <= 1'b1;
                r_best_y     <= w_cur.y;
                r_best_idx   <= w_cur_idx;
              end
            end else if (r_best_found) begin
              r_valid[r_best_idx] <= 1'b0;
              r_active_count      <= r_active_count - 1'b1;
              r_hit_pulse         <= 1'b1;
              r_pkt_data          <= make_pkt(r_best_idx, 6'd0, 10'd0, 10'd0);
              r_pkt_valid         <= 1'b1;
              r_state             <= ST_EMIT;
              r_ret_state         <= ST_IDLE;
            end else begin
              r_whiff_pulse <= 1'b1;
              r_state       <= ST_IDLE;
            end
          end
          ST_CLEAR: begin
            if (w_idx_done) begin
              r_state <= ST_IDLE;
            end else begin
              r_pkt_data  <= make_pkt(w_cur_idx, 6'd0, 10'd0, 10'd0);
              r_pkt_valid <= 1'b1;
              r_state     <= ST_EMIT;
              r_ret_state <= ST_CLEAR;
              r_idx       <= r_idx + 1'b1;
            end
          end
          ST_EMIT: begin
            if (i_pkt_ready) begin
              r_pkt_valid <= 1'b0;
              r_state     <= r_ret_state;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
      if (i_frame_tick) r_frame_pend <= 1'b1;
      if (i_clear_all)  r_clear_pend <= 1'b1;
    end
  end

  assign o_pkt_valid    = r_pkt_valid;
  assign o_pkt_data     = r_pkt_data;
  assign o_hit_pulse    = r_hit_pulse;
  assign o_whiff_pulse  = r_whiff_pulse;
  assign o_miss_pulse   = r_miss_pulse;
  assign o_active_count = r_active_count;

endmodule

// File: tb/tb_note_scroller.sv
// Randomised self-checking bench for note_scroller against a slot-array
// reference model of the scrolling, hit and clear rules.
module tb_note_scroller;

  logic        clk = 1'b0;
  logic        reset, frame_tick, spawn_valid, hit_valid, clear_all, pkt_ready;
  logic [2:0]  speed;
  logic [1:0]  spawn_lane, hit_lane;
  logic [5:0]  spawn_id;
  logic        spawn_ready, hit_ready, pkt_valid, hit_pulse, whiff_pulse, miss_pulse;
  logic [31:0] pkt_data;
  logic [6:0]  active_count;

  always #10 clk = ~clk;

  note_scroller dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_frame_tick   (frame_tick),
    .i_speed        (speed),
    .i_spawn_valid  (spawn_valid),
    .o_spawn_ready  (spawn_ready),
    .i_spawn_lane   (spawn_lane),
    .i_spawn_id     (spawn_id),
    .i_hit_valid    (hit_valid),
    .o_hit_ready    (hit_ready),
    .i_hit_lane     (hit_lane),
    .i_clear_all    (clear_all),
    .o_pkt_valid    (pkt_valid),
    .i_pkt_ready    (pkt_ready),
    .o_pkt_data     (pkt_data),
    .o_hit_pulse    (hit_pulse),
    .o_whiff_pulse  (whiff_pulse),
    .o_miss_pulse   (miss_pulse),
    .o_active_count (active_count)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one entry per slot, updated with plain arithmetic.
  bit  m_valid [64];
  int  m_lane  [64];
  int  m_id    [64];
  int  m_y     [64];
  logic [31:0] exp_q [$];
  int  exp_miss;

  function automatic logic [31:0] pk(input int slot, input int id, input int y, input int x);
    return 32'((slot << 26) | (id << 20) | (y << 10) | x);
  endfunction

  function automatic int m_count();
    int n = 0;
    for (int s = 0; s < 64; s++) if (m_valid[s]) n++;
    return n;
  endfunction

  function automatic int m_free();
    for (int s = 0; s < 64; s++) if (!m_valid[s]) return s;
    return -1;
  endfunction

  task automatic model_scan(input int spd);
    for (int s = 0; s < 64; s++) begin
      if (m_valid[s]) begin
        if (m_y[s] + spd < 480) begin
          m_y[s] = m_y[s] + spd;
          exp_q.push_back(pk(s, m_id[s], m_y[s], 120 * m_lane[s] + 44));
        end else begin
          m_valid[s] = 1'b0;
          exp_q.push_back(pk(s, 0, 0, 0));
          exp_miss++;
        end
      end
    end
  endtask

  // Monitor: drives pkt_ready, records transfers, counts pulses, checks hold.
  logic [31:0] got_q [$];
  int  n_hit, n_whiff, n_miss;
  int  bp_pct = 0;
  bit  hold_ready = 1'b0;
  bit  prev_stall = 1'b0;
  logic [31:0] prev_data;

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("pkt_hold_valid", {31'd0, pkt_valid}, 32'd1);
        check("pkt_hold_data", pkt_data, prev_data);
      end
      if (hit_pulse)   n_hit++;
      if (whiff_pulse) n_whiff++;
      if (miss_pulse)  n_miss++;
    end
    pkt_ready = hold_ready ? 1'b0 : (int'($urandom_range(99)) >= bp_pct);
    if (reset === 1'b0 && pkt_valid && pkt_ready) got_q.push_back(pkt_data);
    prev_stall = (reset === 1'b0) && pkt_valid && !pkt_ready;
    prev_data  = pkt_data;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pkts(input int n);
    int to = 0;
    while (got_q.size() < n && to < 5000) begin
      @(negedge clk);
      to++;
    end
  endtask

  task automatic compare_pkts(input string tag);
    check({tag, "_npkt"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) check(tag, got_q[i], exp_q[i]);
  endtask

  task automatic do_spawn(input int lane, input int id);
    int slot = m_free();
    int to = 0;
    got_q.delete();
    @(negedge clk);
    spawn_valid = 1'b1; spawn_lane = 2'(lane); spawn_id = 6'(id);
    #1;
    while (!spawn_ready && to < 200) begin
      @(negedge clk); #1; to++;
    end
    check("spawn_ready", {31'd0, spawn_ready}, 32'd1);
    @(negedge clk);
    spawn_valid = 1'b0;
    m_valid[slot] = 1'b1; m_lane[slot] = lane; m_id[slot] = id; m_y[slot] = 0;
    #1;
    check("spawn_count", {25'd0, active_count}, m_count());
    check("spawn_nopkt", got_q.size(), 0);
  endtask

  task automatic do_tick(input int spd);
    exp_q.delete(); exp_miss = 0;
    model_scan(spd);
    got_q.delete(); n_miss = 0;
    @(negedge clk);
    speed = 3'(spd); frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    wait_pkts(exp_q.size());
    cyc(70);
    compare_pkts("tick_pkt");
    check("tick_miss", n_miss, exp_miss);
    check("tick_count", {25'd0, active_count}, m_count());
  endtask

  task automatic do_hit(input int lane);
    int best = -1;
    int to = 0;
    for (int s = 0; s < 64; s++)
      if (m_valid[s] && m_lane[s] == lane && m_y[s] >= 400 && m_y[s] <= 479)
        if (best < 0 || m_y[s] > m_y[best]) best = s;
    exp_q.delete();
    if (best >= 0) begin
      m_valid[best] = 1'b0;
      exp_q.push_back(pk(best, 0, 0, 0));
    end
    got_q.delete(); n_hit = 0; n_whiff = 0;
    @(negedge clk);
    hit_valid = 1'b1; hit_lane = 2'(lane);
    #1;
    while (!hit_ready && to < 200) begin
      @(negedge clk); #1; to++;
    end
    check("hit_ready", {31'd0, hit_ready}, 32'd1);
    @(negedge clk);
    hit_valid = 1'b0;
    wait_pkts(exp_q.size());
    cyc(80);
    compare_pkts("hit_pkt");
    check("hit_pulse", n_hit, (best >= 0) ? 1 : 0);
    check("whiff_pulse", n_whiff, (best >= 0) ? 0 : 1);
    check("hit_count", {25'd0, active_count}, m_count());
  endtask

  task automatic do_clear();
    exp_q.delete();
    for (int s = 0; s < 64; s++) begin
      m_valid[s] = 1'b0;
      exp_q.push_back(pk(s, 0, 0, 0));
    end
    got_q.delete();
    @(negedge clk);
    clear_all = 1'b1;
    @(negedge clk);
    clear_all = 1'b0;
    wait_pkts(64);
    cyc(10);
    compare_pkts("clear_pkt");
    check("clear_count", {25'd0, active_count}, 32'd0);
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; frame_tick = 1'b0; speed = 3'd0; spawn_valid = 1'b1; spawn_lane = 2'd0;
    spawn_id = 6'd1; hit_valid = 1'b1; hit_lane = 2'd0; clear_all = 1'b0;
    for (int s = 0; s < 64; s++) begin
      m_valid[s] = 1'b0; m_lane[s] = 0; m_id[s] = 0; m_y[s] = 0;
    end
    cyc(3);
    #1;
    check("rst_pkt_valid", {31'd0, pkt_valid}, 32'd0);
    check("rst_count", {25'd0, active_count}, 32'd0);
    check("rst_spawn_ready", {31'd0, spawn_ready}, 32'd0);
    check("rst_hit_ready", {31'd0, hit_ready}, 32'd0);
    spawn_valid = 1'b0; hit_valid = 1'b0;
    @(negedge clk); #3 reset = 1'b0;
    cyc(2); #1;
    check("idle_spawn_ready", {31'd0, spawn_ready}, 32'd1);

    // First note: lane 2, id 5, advanced by 4.
    do_spawn(2, 5);
    do_tick(4);
    if (got_q.size() > 0) check("first_pkt", got_q[0], pk(0, 5, 4, 284));
    check("first_count", {25'd0, active_count}, 32'd1);

    // Drive that note to y=476 then off the bottom.
    for (int i = 0; i < 67; i++) do_tick(7);
    do_tick(3);
    do_tick(4);
    check("miss_count", {25'd0, active_count}, 32'd0);

    // Two lane-1 notes ending at y=450 (slot 0) and y=410 (slot 1).
    do_spawn(1, 10);
    for (int i = 0; i < 5; i++) do_tick(7);
    do_tick(5);
    do_spawn(1, 11);
    for (int i = 0; i < 58; i++) do_tick(7);
    do_tick(4);
    do_hit(1);
    do_hit(3);

    // Backpressure during a scan, plus two extra ticks folding into one rescan.
    do_spawn(0, 20);
    do_spawn(3, 21);
    exp_q.delete(); exp_miss = 0;
    model_scan(1);
    model_scan(1);
    got_q.delete(); n_miss = 0;
    hold_ready = 1'b1;
    @(negedge clk);
    speed = 3'd1; frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    for (int to = 0; to < 200 && !pkt_valid; to++) @(negedge clk);
    check("stall_valid", {31'd0, pkt_valid}, 32'd1);
    frame_tick = 1'b1; @(negedge clk); frame_tick = 1'b0;
    cyc(2);
    frame_tick = 1'b1; @(negedge clk); frame_tick = 1'b0;
    cyc(6);
    hold_ready = 1'b0;
    wait_pkts(exp_q.size());
    cyc(150);
    compare_pkts("rescan_pkt");
    check("rescan_miss", n_miss, exp_miss);

    // Random mix of spawns, ticks and hits under random backpressure.
    bp_pct = 30;
    for (int k = 0; k < 100; k++) begin
      int r = int'($urandom_range(9));
      if (r < 3 && m_free() >= 0) do_spawn(int'($urandom_range(3)), int'($urandom_range(63, 1)));
      else if (r < 8) do_tick(($urandom_range(9) == 0) ? 0 : int'($urandom_range(7, 3)));
      else do_hit(int'($urandom_range(3)));
    end

    // Fill every slot, then clear.
    bp_pct = 0;
    while (m_free() >= 0) do_spawn(int'($urandom_range(3)), int'($urandom_range(63, 1)));
    check("full_count", {25'd0, active_count}, 32'd64);
    check("full_spawn_ready", {31'd0, spawn_ready}, 32'd0);
    bp_pct = 20;
    do_clear();
    #1;
    check("clear_spawn_ready", {31'd0, spawn_ready}, 32'd1);

    // Reset in the middle of a scan.
    bp_pct = 0;
    for (int i = 0; i < 4; i++) do_spawn(i, 30 + i);
    got_q.delete();
    @(negedge clk);
    speed = 3'd2; frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    for (int to = 0; to < 200 && got_q.size() < 1; to++) @(negedge clk);
    check("mid_scan_started", {31'd0, (got_q.size() >= 1) ? 1'b1 : 1'b0}, 32'd1);
    #3 reset = 1'b1;
    #1;
    check("rst_mid_pkt_valid", {31'd0, pkt_valid}, 32'd0);
    check("rst_mid_count", {25'd0, active_count}, 32'd0);
    for (int s = 0; s < 64; s++) m_valid[s] = 1'b0;
    cyc(2);
    #3 reset = 1'b0;
    got_q.delete();
    cyc(30);
    #1;
    check("post_rst_nopkt", got_q.size(), 0);
    check("post_rst_spawn_ready", {31'd0, spawn_ready}, 32'd1);
    check("post_rst_count", {25'd0, active_count}, 32'd0);
    do_spawn(2, 9);
    do_tick(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/note_scroller.md
NOTE_SCROLLER -- requirements
Module: note_scroller

Interface
REQ-001 Parameter LANES, default 4, number of note lanes (fixed at 4; lane field is 2 bits).
REQ-002 Parameter SLOTS, default 64, note slots; equals sprite table depth of the display stage.
REQ-003 Parameter HIT_Y_LO, default 10'd400, lowest y accepted by a hit.
REQ-004 clk  in  1  system clock, 50 MHz.
REQ-005 reset  in  1  asynchronous, active-high.
REQ-006 frame_tick  in  1  one-cycle pulse at start of vertical blank.
REQ-007 speed  in  3  pixels per frame; 0 = paused.
REQ-008 spawn_valid/spawn_ready  in/out  1/1  spawn handshake; spawn_lane in 2, spawn_id in 6 (1-63).
REQ-009 hit_valid/hit_ready  in/out  1/1  player hit handshake; hit_lane in 2.
REQ-010 clear_all  in  1  one-cycle pulse; empties all slots.
REQ-011 pkt_valid/pkt_ready  out/in  1/1  packet handshake toward display stage.
REQ-012 pkt_data  out  32  [31:26] slot, [25:20] id, [19:10] y, [9:0] x.
REQ-013 hit_pulse, whiff_pulse, miss_pulse  out  1 each  one-cycle event flags.
REQ-014 active_count  out  7  number of valid slots, 0-64.

Function
REQ-015 Per slot: valid, lane(2), id(6), y(10); lane x = 120*lane + 44 (44/164/284/404).
REQ-016 FSM states IDLE, SCAN, HIT, CLEAR, EMIT; EMIT returns to the state that entered it.
REQ-017 frame_tick in any state sets frame_pend; ticks while frame_pend set are dropped.
REQ-018 IDLE priority: clear_pend > frame_pend > hit_valid > spawn_valid; one action per cycle.
REQ-019 spawn_ready = IDLE, no higher-priority request, and a free slot exists; accept writes lowest-index free slot, y=0, no packet.
REQ-020 SCAN: latch speed, clear frame_pend, visit slots 0..63 one per cycle; invalid slots skipped.
REQ-021 SCAN valid slot: y_new = y + speed in 11 bits; y_new < 480 -> store, emit {slot,id,y_new,x}; else invalidate, emit {slot,0,0,0}, miss_pulse.
REQ-022 HIT: hit_ready high one cycle in IDLE on accept; scan all 64 slots for valid, lane match, HIT_Y_LO <= y <= 479, choose largest y, ties to lowest index.
REQ-023 HIT end: match -> invalidate, emit clear packet, hit_pulse; none -> whiff_pulse, no packet; completes in 65 cycles plus EMIT time.
REQ-024 EMIT: pkt_valid held high, pkt_data stable until pkt_ready; transfer on cycle both high; pkt_valid low otherwise.
REQ-025 clear_all sets clear_pend; current packet finishes, then CLEAR invalidates all slots and emits {i,0,0,0} for i = 0..63; aborts in-progress SCAN/HIT.
REQ-026 active_count updates the cycle after any spawn, retire or hit.
REQ-027 speed = 0: SCAN still re-emits every valid slot unchanged.

Reset
REQ-028 Reset asynchronously clears all valid bits, pend flags, pulses, pkt_valid, active_count; FSM to IDLE; spawn_ready/hit_ready 0.
REQ-029 Reset mid-SCAN/HIT/EMIT abandons the operation; no packet after deassertion until new activity.
REQ-030 Slot lane/id/y contents need no reset.

Structure
REQ-031 Shared package holds packet field positions, lane x table, screen height 480, slot typedef.
REQ-032 One sub-module, slot_prio_enc: 64-bit mask in -> lowest set index + any flag; used for free-slot search.

Verification
REQ-033 Spawn lane 2 id 5, speed 4, pkt_ready=1, one tick -> one packet 32'h(slot0,5,4,284), active_count 1.
REQ-034 Note at y=476, speed 4, tick -> packet {0,0,0,0}, miss_pulse, active_count 0.
REQ-035 Notes lane 1 at y 410 and 450, hit lane 1 -> slot with y 450 cleared, hit_pulse; hit lane 3 -> whiff_pulse, no packet.
REQ-036 Hold pkt_ready=0 10 cycles during SCAN -> pkt_data stable, two extra ticks -> exactly one follow-up scan.
REQ-037 Fill 64 slots -> spawn_ready 0; clear_all -> 64 clear packets, active_count 0, spawn_ready 1.
REQ-038 Assert reset mid-SCAN -> pkt_valid 0 immediately, active_count 0, IDLE after release.
